// File: rtl/request_unit.sv
// request_unit: sequences instruction/data memory requests for a single-cycle
// datapath, gates PC advance, latches halt and keeps saturating
// retired-instruction and stall-cycle performance counters.
module request_unit #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             cu_dREN,
    input  logic             cu_dWEN,
    input  logic             cu_halt,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pcEN,
    output logic             halt,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg;
    state_t           state_next;
    logic             halt_reg;
    logic             halt_next;
    logic             instr_inc;
    logic             stall_inc;
    logic [CNT_W-1:0] instr_count_reg;
    logic [CNT_W-1:0] stall_count_reg;

    // State and sticky halt register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= FETCH;
            halt_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            halt_reg  <= halt_next;
        end
    end

    // Performance counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr_count_reg <= '0;
            stall_count_reg <= '0;
        end else begin
            if (instr_inc && (instr_count_reg != CNT_MAX)) begin
                instr_count_reg <= instr_count_reg + CNT_ONE;
            end
            if (stall_inc && (stall_count_reg != CNT_MAX)) begin
                stall_count_reg <= stall_count_reg + CNT_ONE;
            end
        end
    end

    // Next-state, request decode and counter-increment strobes.
    always_comb begin
        state_next = state_reg;
        halt_next  = halt_reg;
        imemREN    = 1'b0;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        pcEN       = 1'b0;
        instr_inc  = 1'b0;
        stall_inc  = 1'b0;

        case (state_reg)
            FETCH: begin
                imemREN = 1'b1;
                if (!ihit) begin
                    stall_inc = 1'b1;
                end else if (cu_halt) begin
                    // Halt wins over any memory op carried by the same word.
                    state_next = HALTED;
                    halt_next  = 1'b1;
                    instr_inc  = 1'b1;
                end else if (cu_dREN || cu_dWEN) begin
                    state_next = DATA;
                end else begin
                    pcEN      = 1'b1;
                    instr_inc = 1'b1;
                end
            end
            DATA: begin
                // The PC is held, so cu_* stay valid for the whole access.
                dmemWEN = cu_dWEN;
                dmemREN = cu_dREN & ~cu_dWEN;
                if (dhit) begin
                    pcEN       = 1'b1;
                    instr_inc  = 1'b1;
                    state_next = FETCH;
                end else begin
                    stall_inc = 1'b1;
                end
            end
            HALTED: begin
                halt_next = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // Requests must vanish the moment reset is applied, not at the next edge.
        if (RST) begin
            imemREN = 1'b0;
            dmemREN = 1'b0;
            dmemWEN = 1'b0;
            pcEN    = 1'b0;
        end
    end

    assign halt        = halt_reg;
    assign instr_count = instr_count_reg;
    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: directed scoreboard bench for request_unit (32-bit and
// 4-bit counter instances driven by the same stimulus).
module tb_request_unit;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic        dhit;
    logic        cu_dREN;
    logic        cu_dWEN;
    logic        cu_halt;
    logic        imemREN;
    logic        dmemREN;
    logic        dmemWEN;
    logic        pcEN;
    logic        halt;
    logic [31:0] instr_count;
    logic [31:0] stall_count;

    logic        imemREN4;
    logic        dmemREN4;
    logic        dmemWEN4;
    logic        pcEN4;
    logic        halt4;
    logic [3:0]  instr_count4;
    logic [3:0]  stall_count4;

    int total = 0;
    int bad   = 0;

    request_unit #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .pcEN(pcEN), .halt(halt),
        .instr_count(instr_count), .stall_count(stall_count)
    );

    request_unit #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
        .imemREN(imemREN4), .dmemREN(dmemREN4), .dmemWEN(dmemWEN4),
        .pcEN(pcEN4), .halt(halt4),
        .instr_count(instr_count4), .stall_count(stall_count4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic        imem;
        logic        dren;
        logic        dwen;
        logic        pcen;
        logic        hlt;
        logic [31:0] ic;
        logic [31:0] sc;
        logic [31:0] ic4;
        logic [31:0] sc4;
    } exp_t;

    exp_t q[$];

    // Reference model state: 0=FETCH 1=DATA 2=HALTED
    int          m_state;
    logic        m_halt;
    logic [31:0] m_ic;
    logic [31:0] m_sc;
    logic [31:0] m_ic4;
    logic [31:0] m_sc4;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
        return (v == maxv) ? v : v + 32'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_halt  = 1'b0;
        m_ic    = 32'd0;
        m_sc    = 32'd0;
        m_ic4   = 32'd0;
        m_sc4   = 32'd0;
    endtask

    // Predict this cycle's outputs from the current inputs, push them, then
    // advance the model across the coming edge.
    task automatic model_step();
        exp_t e;
        logic inc_i;
        logic inc_s;
        inc_i  = 1'b0;
        inc_s  = 1'b0;
        e      = '0;
        e.imem = (m_state == 0);
        e.dwen = (m_state == 1) && cu_dWEN;
        e.dren = (m_state == 1) && cu_dREN && !cu_dWEN;
        e.pcen = ((m_state == 0) && ihit && !cu_halt && !cu_dREN && !cu_dWEN)
              || ((m_state == 1) && dhit);
        if (m_state == 0) begin
            if (!ihit) inc_s = 1'b1;
            else if (cu_halt) begin
                m_state = 2;
                m_halt  = 1'b1;
                inc_i   = 1'b1;
            end else if (cu_dREN || cu_dWEN) begin
                m_state = 1;
            end else inc_i = 1'b1;
        end else if (m_state == 1) begin
            if (!cu_dREN && !cu_dWEN)
                $display("protocol violation: data phase with no request");
            if (dhit) begin
                m_state = 0;
                inc_i   = 1'b1;
            end else inc_s = 1'b1;
        end
        if (inc_i) begin
            m_ic  = sat_inc(m_ic, 32'hFFFF_FFFF);
            m_ic4 = sat_inc(m_ic4, 32'd15);
        end
        if (inc_s) begin
            m_sc  = sat_inc(m_sc, 32'hFFFF_FFFF);
            m_sc4 = sat_inc(m_sc4, 32'd15);
        end
        e.hlt = m_halt;
        e.ic  = m_ic;
        e.sc  = m_sc;
        e.ic4 = m_ic4;
        e.sc4 = m_sc4;
        q.push_back(e);
    endtask

    // One clock transaction; called at posedge+1.
    task automatic cyc(input logic ih, input logic dh, input logic dr,
                       input logic dw, input logic hl);
        exp_t e;
        ihit = ih; dhit = dh; cu_dREN = dr; cu_dWEN = dw; cu_halt = hl;
        model_step();
        #3;
        if (q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk("imemREN", {31'd0, imemREN}, {31'd0, e.imem});
            chk("dmemREN", {31'd0, dmemREN}, {31'd0, e.dren});
            chk("dmemWEN", {31'd0, dmemWEN}, {31'd0, e.dwen});
            chk("pcEN", {31'd0, pcEN}, {31'd0, e.pcen});
            @(posedge CLK);
            #1;
            chk("halt", {31'd0, halt}, {31'd0, e.hlt});
            chk("instr_count", instr_count, e.ic);
            chk("stall_count", stall_count, e.sc);
            chk("instr_count4", {28'd0, instr_count4}, e.ic4);
            chk("stall_count4", {28'd0, stall_count4}, e.sc4);
            $display("txn ih=%b dh=%b dr=%b dw=%b hl=%b -> imem=%b dren=%b dwen=%b pc=%b halt=%b ic=%0d sc=%0d ic4=%0d",
                     ih, dh, dr, dw, hl, e.imem, e.dren, e.dwen, e.pcen,
                     halt, instr_count, stall_count, instr_count4);
        end
    endtask

    // Hold reset for two edges; called at posedge+1 (or time 0).
    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst_imemREN", {31'd0, imemREN}, 32'd0);
        chk("rst_pcEN", {31'd0, pcEN}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_instr_count", instr_count, 32'd0);
        chk("rst_stall_count", stall_count, 32'd0);
        model_reset();
        RST = 1'b0;
    endtask

    initial begin
        ihit = 1'b1; dhit = 1'b0; cu_dREN = 1'b0; cu_dWEN = 1'b0; cu_halt = 1'b0;
        RST  = 1'b0;
        model_reset();

        // Reset, then five single-cycle instructions.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
        chk("plan_ic5", instr_count, 32'd5);
        chk("plan_sc0", stall_count, 32'd0);

        // Twenty more: the 4-bit instance pins at 15.
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0);
        chk("sat_ic4", {28'd0, instr_count4}, 32'd15);
        chk("sat_ic32", instr_count, 32'd25);

        // lw with three data stall cycles.
        do_reset();
        cyc(1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("lw_sc3", stall_count, 32'd3);
        chk("lw_ic1", instr_count, 32'd1);
        cyc(1, 0, 0, 0, 0);

        // Read and write both asserted: write wins; spurious ihit in DATA ignored.
        cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 1, 1, 0);
        cyc(0, 1, 1, 1, 0);
        // Immediate sw: two cycles; spurious dhit in FETCH ignored.
        cyc(1, 1, 0, 1, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);

        // Halt after four fetch stalls, with a store carried alongside.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 1);
        chk("halt_sc4", stall_count, 32'd4);
        chk("halt_set", {31'd0, halt}, 32'd1);
        for (int i = 0; i < 4; i++) cyc(i[0], ~i[0], 1, 1, 0);
        chk("halt_ic1", instr_count, 32'd1);

        // Reset in the middle of a store.
        do_reset();
        cyc(1, 0, 0, 1, 0);
        ihit = 1'b0; dhit = 1'b0; cu_dREN = 1'b0; cu_dWEN = 1'b1; cu_halt = 1'b0;
        #2;
        chk("mid_dwen_before", {31'd0, dmemWEN}, 32'd1);
        RST = 1'b1;
        #1;
        chk("mid_dwen_async", {31'd0, dmemWEN}, 32'd0);
        chk("mid_imem_async", {31'd0, imemREN}, 32'd0);
        chk("mid_ic_async", instr_count, 32'd0);
        @(posedge CLK);
        #1;
        model_reset();
        RST = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("mid_fetch_sc", stall_count, 32'd1);
        chk("mid_fetch_ic", instr_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
